// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, defaults and counter width for the stalling data memory
package dmem_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;
    localparam int LAT_DEF   = 4;
    localparam int WORDS_DEF = 256;
    localparam int CNT_W     = 4;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: 16-bit word storage with synchronous write and combinational read
module dmem_array #(
    parameter int WORDS = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(WORDS)-1:0] waddr,
    input  logic [15:0]              wdata,
    input  logic [$clog2(WORDS)-1:0] raddr,
    output logic [15:0]              rdata
);
    logic [15:0] mem_q [WORDS];
    // write port; contents survive reset on purpose
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end
    assign rdata = mem_q[raddr];
endmodule

// File: rtl/dmem_stall_ctrl.sv
// dmem_stall_ctrl: fixed-latency data memory that stalls the MEM stage until the access completes
module dmem_stall_ctrl
    import dmem_pkg::*;
#(
    parameter int LAT   = LAT_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Stall,
    output logic        Done,
    output logic        err
);
    localparam int AW = $clog2(WORDS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [15:0]      data_q, data_d;
    logic             wr_q, wr_d;
    logic             done_q, done_d;
    logic             legal, illegal, idle;
    logic [15:0]      rdata;
    logic             unused_addr;

    assign idle        = (state_q == IDLE);
    assign legal       = (Rd ^ Wr) & ~Addr[0];
    assign illegal     = (Rd & Wr) | ((Rd | Wr) & Addr[0]);
    assign unused_addr = ^Addr;

    // Stall covers the acceptance cycle itself; both flags are masked while reset is held
    assign Stall   = ~rst & ((idle & legal) | (state_q == BUSY));
    assign err     = ~rst & idle & illegal;
    assign Done    = done_q;
    assign DataOut = (done_q & ~wr_q) ? rdata : 16'h0000;

    dmem_array #(.WORDS(WORDS)) u_array (
        .clk   (clk),
        .we    (done_q & wr_q),
        .waddr (idx_q),
        .wdata (data_q),
        .raddr (idx_q),
        .rdata (rdata)
    );

    // next state: capture on acceptance, count down while busy, DONE always falls back to IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                if (legal) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(LAT - 1);
                    idx_d   = Addr[AW:1];
                    data_d  = DataIn;
                    wr_d    = Wr;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
    end

    // state, counter and capture registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// tb_dmem_stall_ctrl: scoreboard bench for the stalling data memory controller
module tb_dmem_stall_ctrl;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr, din, dout;
    logic        rd, wr, stall, done, err;
    logic [15:0] addr2, din2, dout2;
    logic        rd2, wr2, stall2, done2, err2;
    logic [15:0] ref_mem [256];
    logic [15:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dmem_stall_ctrl #(.LAT(LAT), .WORDS(256)) u_dut (
        .clk(clk), .rst(rst), .Addr(addr), .DataIn(din), .Rd(rd), .Wr(wr),
        .DataOut(dout), .Stall(stall), .Done(done), .err(err)
    );

    dmem_stall_ctrl #(.LAT(2), .WORDS(256)) u_dut2 (
        .clk(clk), .rst(rst), .Addr(addr2), .DataIn(din2), .Rd(rd2), .Wr(wr2),
        .DataOut(dout2), .Stall(stall2), .Done(done2), .err(err2)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one legal access on the LAT=4 instance; optionally scramble Addr/DataIn in cycle 2
    task automatic access(input string tag, input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] d, input bit scramble);
        int stalls = 0;
        int c = 0;
        bit seen = 0;
        logic [7:0] idx;
        idx = a[8:1];
        exp_q.push_back(r ? ref_mem[idx] : 16'h0000);
        rd = r; wr = w; addr = a; din = d;
        while (!seen && c < 40) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                check({tag, "_stall_at_done"}, 16'(stall), 16'h0);
                check({tag, "_done_cycle"}, 16'(c), 16'(LAT));
                check({tag, "_data"}, dout, exp_q.pop_front());
            end else if (stall) begin
                stalls++;
            end
            step();
            c++;
            if (scramble && c == 2) begin
                addr = a ^ 16'h00F0;
                din  = ~d;
            end
        end
        rd = 0; wr = 0;
        if (!seen) begin
            check({tag, "_timeout"}, 16'h0, 16'h1);
            void'(exp_q.pop_front());
        end else begin
            check({tag, "_stall_cycles"}, 16'(stalls), 16'(LAT));
            if (w) ref_mem[idx] = d;
        end
    endtask

    // illegal request: err now, no stall, and no completion afterwards
    task automatic illegal(input string tag, input logic r, input logic w,
                           input logic [15:0] a, input logic [15:0] d);
        int dones = 0;
        rd = r; wr = w; addr = a; din = d;
        #1;
        check({tag, "_err"}, 16'(err), 16'h1);
        check({tag, "_stall"}, 16'(stall), 16'h0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) dones++;
            step();
        end
        check({tag, "_no_done"}, 16'(dones), 16'h0);
        rd = 0; wr = 0;
    endtask

    // held request on the LAT=2 instance: one Done, two stall cycles, no restart
    task automatic held2(input string tag, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d, input logic [15:0] exp);
        int dones = 0;
        int stalls = 0;
        rd2 = r; wr2 = w; addr2 = a; din2 = d;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (stall2) stalls++;
            if (done2) begin
                dones++;
                check({tag, "_stall_at_done"}, 16'(stall2), 16'h0);
                check({tag, "_data"}, dout2, exp);
            end
            step();
            if (c == 2) begin
                rd2 = 0; wr2 = 0;
            end
        end
        check({tag, "_done_count"}, 16'(dones), 16'h1);
        check({tag, "_stall_cycles"}, 16'(stalls), 16'h2);
    endtask

    initial begin
        rst = 1; rd = 0; wr = 0; addr = 0; din = 0;
        rd2 = 0; wr2 = 0; addr2 = 0; din2 = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'hxxxx;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 16'(stall), 16'h0);
        check("rst_done", 16'(done), 16'h0);
        check("rst_err", 16'(err), 16'h0);
        check("rst_dout", dout, 16'h0);
        rst = 0;
        step();

        access("pre20", 0, 1, 16'h0020, 16'h2020, 0);
        access("pre08", 0, 1, 16'h0008, 16'h4444, 0);
        access("pre02", 0, 1, 16'h0002, 16'h1111, 0);
        access("pre04", 0, 1, 16'h0004, 16'h2222, 0);
        access("pre06", 0, 1, 16'h0006, 16'h3333, 0);
        access("preF4", 0, 1, 16'h00F4, 16'h7A7A, 0);

        access("st_beef", 0, 1, 16'h0010, 16'hBEEF, 0);
        access("ld_beef", 1, 0, 16'h0010, 16'h0000, 0);

        illegal("misalign", 1, 0, 16'h0011, 16'h0000);
        illegal("rdwr", 1, 1, 16'h0020, 16'hDEAD);
        access("ld_20", 1, 0, 16'h0020, 16'h0000, 0);

        access("st_busychg", 0, 1, 16'h0004, 16'h1234, 1);
        access("ld_w2", 1, 0, 16'h0004, 16'h0000, 0);
        access("ld_w1", 1, 0, 16'h0002, 16'h0000, 0);
        access("ld_w3", 1, 0, 16'h0006, 16'h0000, 0);
        access("ld_wF4", 1, 0, 16'h00F4, 16'h0000, 0);

        rd = 0; wr = 1; addr = 16'h0008; din = 16'hAAAA;
        step();
        step();
        rst = 1;
        #1;
        check("abort_stall", 16'(stall), 16'h0);
        check("abort_done", 16'(done), 16'h0);
        check("abort_err", 16'(err), 16'h0);
        check("abort_dout", dout, 16'h0);
        wr = 0;
        step();
        rst = 0;
        step();
        access("ld_w4", 1, 0, 16'h0008, 16'h0000, 0);

        access("st_wrap", 0, 1, 16'h0202, 16'h5555, 0);
        access("ld_wrap", 1, 0, 16'h0002, 16'h0000, 0);

        held2("held_wr", 0, 1, 16'h0030, 16'h7777, 16'h0000);
        held2("held_rd", 1, 0, 16'h0030, 16'h0000, 16'h7777);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_stall_ctrl.md
DMEM_STALL_CTRL -- requirements
Module: dmem_stall_ctrl

Interface
REQ-001 Parameter LAT, default 4: cycles from request acceptance to Done; legal range 2..15.
REQ-002 Parameter WORDS, default 256: number of 16-bit words in the internal array; power of two.
REQ-003 clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 Addr  input  16  byte address from the MEM stage.
REQ-006 DataIn  input  16  store data.
REQ-007 Rd  input  1  load request.
REQ-008 Wr  input  1  store request.
REQ-009 DataOut  output  16  load data; valid only while Done=1.
REQ-010 Stall  output  1  the MEM stage must hold its pipeline register; drives the pipeline's d_Stall.
REQ-011 Done  output  1  one-cycle pulse marking access completion; drives the pipeline's d_done.
REQ-012 err  output  1  illegal request flag.

Function
REQ-013 The block SHALL form the word index from Addr[log2(WORDS):1], truncating upper bits so that addresses wrap modulo 2*WORDS bytes.
REQ-014 The block SHALL flag a request as illegal when (Rd&Wr)=1, or when (Rd|Wr)=1 and Addr[0]=1.
REQ-015 The block SHALL assert err combinationally in IDLE for an illegal request, SHALL NOT assert Stall for it, and SHALL leave the array unmodified.
REQ-016 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-017 In IDLE, a legal request (Rd^Wr=1, Addr[0]=0) SHALL be accepted: the block captures word index, DataIn and the Rd/Wr type, loads the counter with LAT-1, and enters BUSY.
REQ-018 Stall SHALL equal (IDLE & legal request) | BUSY, combinationally, so it is high in the acceptance cycle itself.
REQ-019 In BUSY the counter SHALL decrement each cycle, and the FSM SHALL enter DONE on the cycle the counter reaches 1.
REQ-020 For a request accepted in cycle 0, Stall SHALL be high in cycles 0..LAT-1, and Done SHALL be high only in cycle LAT with Stall low.
REQ-021 Done SHALL be a registered output that is high only in DONE.
REQ-022 DONE SHALL return to IDLE unconditionally, ignoring Rd and Wr in that cycle, so the still-held request is not restarted.
REQ-023 A store SHALL update the array on the clock edge ending DONE, using the captured index and data.
REQ-024 A load SHALL present the array word at the captured index on DataOut during DONE; outside DONE, DataOut SHALL be 0.
REQ-025 Changes to Addr, DataIn, Rd or Wr during BUSY or DONE SHALL have no effect.
REQ-026 Back-to-back requests SHALL be accepted no earlier than the cycle after DONE.
REQ-027 A load that immediately follows a store to the same word SHALL return the stored value.

Reset
REQ-028 On rst=1 the block SHALL asynchronously force the FSM to IDLE and clear the counter and captured registers, making Stall, Done, err and DataOut all 0.
REQ-029 A reset during BUSY or DONE SHALL abort the access, with no array write committed.
REQ-030 Array contents SHALL NOT be reset.

Structure
REQ-031 Package dmem_pkg SHALL hold the state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10), the LAT and WORDS defaults, and the counter width of 4 bits.
REQ-032 The storage SHALL be a sub-module dmem_array with a synchronous write port and a combinational read port; the FSM, counter and capture registers stay in dmem_stall_ctrl.

Verification
REQ-033 Store then load (LAT=4): Wr=1, Addr=16'h0010, DataIn=16'hBEEF -> Stall high for 4 cycles and Done in cycle 4; then Rd=1, Addr=16'h0010 -> DataOut=16'hBEEF with Done in cycle 4.
REQ-034 Misaligned and conflicting requests: Rd=1, Addr=16'h0011 -> err=1, Stall=0, no Done; then Rd=Wr=1, Addr=16'h0020 -> err=1, and a later load of 16'h0020 returns its prior value.
REQ-035 Input change while busy: Wr=1, Addr=16'h0004, DataIn=16'h1234, then Addr and DataIn changed in cycle 2 -> word 2 holds 16'h1234 and no other word changes.
REQ-036 Reset mid-access: Wr=1, Addr=16'h0008, DataIn=16'hAAAA, rst pulsed in cycle 2 -> all outputs 0 immediately, and word 4 is unchanged afterwards.
REQ-037 Wrap-around (WORDS=256): store 16'h5555 to Addr=16'h0202, then load Addr=16'h0002 -> DataOut=16'h5555.
REQ-038 Held request: Rd kept high through DONE -> exactly one Done pulse and no re-acceptance; with LAT=2, Stall is high for 2 cycles.
